// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-locked round-robin arbiter for one FIFO write port
// Optional per-grant beat limit: FIFO_WR_ARBITER_BURSTLIMIT_EN (uses MAX_BURST).
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cg,
    input  logic [N_REQ-1:0]         i_valid,
    input  logic [N_REQ*WIDTH-1:0]   i_data,
    input  logic [N_REQ-1:0]         i_last,
    output logic [N_REQ-1:0]         o_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_last,
    input  logic                     i_ready,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            any_req;
    logic            push;
    logic            release_burst;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan from the farthest offset down so the requester nearest ptr+1 wins.
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = IW'((int'(ptr_q) + i) % N_REQ);
            if (i_valid[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    assign push = i_cg && o_valid && i_ready;

`ifdef FIFO_WR_ARBITER_BURSTLIMIT_EN
    assign release_burst = push && (o_last || (cnt_q + CW'(1) == CW'(MAX_BURST)));
`else
    assign release_burst = push && o_last;
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (i_cg) begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_d = BURST;
                        g_d     = pick;
                        cnt_d   = '0;
                    end
                end
                BURST: begin
                    if (release_burst) begin
                        state_d = IDLE;
                        ptr_d   = g_q;
                    end else if (push && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = '0;
        o_grant = '0;
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        o_busy  = 1'b0;
        if (state_q == BURST) begin
            o_busy       = 1'b1;
            o_grant[g_q] = 1'b1;
            o_valid      = i_valid[g_q];
            o_data       = i_data[int'(g_q)*WIDTH +: WIDTH];
            o_last       = i_last[g_q];
            o_ready[g_q] = i_ready && i_cg;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cg;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   o_ready;
    logic [W-1:0]   o_data;
    logic           o_valid;
    logic           o_last;
    logic           ready;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cg(cg), .i_valid(valid), .i_data(data),
        .i_last(last), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
        .o_last(o_last), .i_ready(ready), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".grant"}, 32'(o_grant), 32'h0);
        chk({tag, ".valid"}, 32'(o_valid), 32'h0);
        chk({tag, ".busy"},  32'(o_busy),  32'h0);
        chk({tag, ".ready"}, 32'(o_ready), 32'h0);
    endtask

    task automatic chk_burst(input string tag, input logic [N-1:0] g, input logic v,
                             input logic [N-1:0] rdy, input logic [W-1:0] d);
        chk({tag, ".grant"}, 32'(o_grant), 32'(g));
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".ready"}, 32'(o_ready), 32'(rdy));
        if (v) chk({tag, ".data"}, 32'(o_data), 32'(d));
    endtask

    // Requester 0 streams beats b0..b1 with data 0x30+b; beat 10 carries last.
    task automatic beats0(input int b0, input int b1);
        for (int b = b0; b <= b1; b++) begin
            data[0 +: W] = W'(8'h30 + b);
            last[0]      = (b == 10);
            look();
            chk_burst("t5.beat", 4'b0001, 1'b1, 4'b0001, W'(8'h30 + b));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cg = 1'b1; valid = '0; data = '0; last = '0; ready = 1'b0;
        #3;
        chk_idle("reset");
        chk("reset.data", 32'(o_data), 32'h0);
        chk("reset.last", 32'(o_last), 32'h0);

        // Test 1: everyone always valid with single-beat bursts.
        tick();
        rst_n = 1'b1; valid = 4'hF; last = 4'hF; ready = 1'b1;
        data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        look();
        chk_idle("t1.start");
        for (int k = 0; k < 5; k++) begin
            tick(); look();
            chk_burst("t1.grant", 4'(1 << (k % 4)), 1'b1, 4'(1 << (k % 4)), W'(8'hA0 + (k % 4)));
            chk("t1.last", 32'(o_last), 32'h1);
            tick();
            if (k == 4) valid = '0;
            look();
            chk_idle("t1.bubble");
        end

        // Test 2: requester 2 alone, ready toggling 1,0,1,0,1 (ptr=0 now).
        valid = 4'b0100; data[16 +: 8] = 8'h11; last = '0;
        tick(); look();
        chk_burst("t2.b1", 4'b0100, 1'b1, 4'b0100, 8'h11);
        tick(); data[16 +: 8] = 8'h22; ready = 1'b0; look();
        chk_burst("t2.w1", 4'b0100, 1'b1, 4'b0000, 8'h22);
        tick(); ready = 1'b1; look();
        chk_burst("t2.b2", 4'b0100, 1'b1, 4'b0100, 8'h22);
        tick(); data[16 +: 8] = 8'h33; last[2] = 1'b1; ready = 1'b0; look();
        chk_burst("t2.w2", 4'b0100, 1'b1, 4'b0000, 8'h33);
        tick(); ready = 1'b1; look();
        chk_burst("t2.b3", 4'b0100, 1'b1, 4'b0100, 8'h33);
        chk("t2.last", 32'(o_last), 32'h1);
        tick(); valid = '0; last = '0; look();
        chk_idle("t2.end");

        // Test 3: requester 1 stalls mid-burst while requester 3 waits (ptr=2).
        valid = 4'b0010; data[8 +: 8] = 8'h51;
        tick(); look();
        chk_burst("t3.b1", 4'b0010, 1'b1, 4'b0010, 8'h51);
        tick();
        valid = 4'b1000; data[24 +: 8] = 8'h77; last[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            look();
            chk_burst("t3.hold", 4'b0010, 1'b0, 4'b0010, 8'h00);
            tick();
        end
        valid = 4'b1010; data[8 +: 8] = 8'h52; last[1] = 1'b1; look();
        chk_burst("t3.b2", 4'b0010, 1'b1, 4'b0010, 8'h52);
        tick(); valid = 4'b1000; look();
        chk_idle("t3.bubble");
        tick(); look();
        chk_burst("t3.r3", 4'b1000, 1'b1, 4'b1000, 8'h77);
        tick(); valid = '0; last = '0; look();
        chk_idle("t3.end");

        // Test 5: long burst from 0 with requester 1 pending (ptr=3).
        valid = 4'b0011; data[8 +: 8] = 8'hE0; last = 4'b0010;
        tick();
`ifdef FIFO_WR_ARBITER_BURSTLIMIT_EN
        beats0(0, 3);
        look(); chk_idle("t5.lim1");
        tick(); look();
        chk_burst("t5.r1", 4'b0010, 1'b1, 4'b0010, 8'hE0);
        tick(); valid = 4'b0001; look();
        chk_idle("t5.after1");
        tick();
        beats0(4, 7);
        look(); chk_idle("t5.lim2");
        tick();
        beats0(8, 10);
`else
        beats0(0, 10);
        look(); chk_idle("t5.done0");
        tick(); look();
        chk_burst("t5.r1", 4'b0010, 1'b1, 4'b0010, 8'hE0);
        tick();
`endif
        valid = '0; last = '0; look();
        chk_idle("t5.end");

        // Test 4: clock gate low for 3 cycles mid-burst.
        valid = 4'b0001; data[0 +: 8] = 8'hC1;
        tick(); look();
        chk_burst("t4.b1", 4'b0001, 1'b1, 4'b0001, 8'hC1);
        tick(); data[0 +: 8] = 8'hC2; cg = 1'b0;
        for (int k = 0; k < 3; k++) begin
            look();
            chk_burst("t4.gated", 4'b0001, 1'b1, 4'b0000, 8'hC2);
            tick();
        end
        cg = 1'b1; look();
        chk_burst("t4.b2", 4'b0001, 1'b1, 4'b0001, 8'hC2);
        tick(); data[0 +: 8] = 8'hC3; last[0] = 1'b1; look();
        chk_burst("t4.b3", 4'b0001, 1'b1, 4'b0001, 8'hC3);
        tick(); valid = '0; last = '0; look();
        chk_idle("t4.end");

        // Test 6: reset mid-burst, ptr returns to N-1 so requester 0 wins.
        valid = 4'b0100; data[16 +: 8] = 8'h66;
        tick(); look();
        chk_burst("t6.r2", 4'b0100, 1'b1, 4'b0100, 8'h66);
        tick(); rst_n = 1'b0; look();
        chk_idle("t6.reset");
        tick(); rst_n = 1'b1; valid = 4'b0101; data[0 +: 8] = 8'h01;
        tick(); look();
        chk_burst("t6.regrant", 4'b0001, 1'b1, 4'b0001, 8'h01);
        chk("t6.busy", 32'(o_busy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
